sd_spi_shifter: RTL and testbench

//  SPI mode-0 master byte engine sitting directly downstream of the SD card controller FSM.

---
 rtl/sd_spi_shifter.sv | 187 ++++++++++++++++++
 tb/tb_sd_spi_shifter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_shifter.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_shifter
// Brief    : SPI mode-0 master byte engine. Builds 0xFF fill, TX data or
//            command-frame bytes, shifts them MSB-first, samples miso.
// Revision : 1.0 - initial release
// ============================================================================
module sd_spi_shifter #(
    parameter int unsigned CLK_DIV     = 4,
    parameter logic [7:0]  CMD0_CRC    = 8'h95,
    parameter logic [7:0]  DEFAULT_CRC = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        load_enable,
    input  logic [1:0]  spi_select,
    input  logic [5:0]  cmd_index,
    input  logic [3:0]  byte_index,
    input  logic [31:0] addr,
    input  logic [7:0]  tx_data,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        byte_transf,
    output logic [7:0]  rx_byte,
    output logic        edge_detect,
    output logic        busy
);

    localparam int unsigned        c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [2:0]           r_bit_cnt;
    logic [7:0]           r_tx_shift;
    logic [7:0]           r_rx_shift;
    logic [7:0]           r_hold_byte;
    logic                 r_pending;
    logic                 r_miso_prev;

    state_t               w_state_nxt;
    logic [c_DIV_W-1:0]   w_div_nxt;
    logic [2:0]           w_bit_nxt;
    logic [7:0]           w_tx_nxt;
    logic [7:0]           w_rx_nxt;
    logic [7:0]           w_hold_nxt;
    logic                 w_pend_nxt;
    logic                 w_miso_prev_nxt;
    logic                 w_transf_nxt;
    logic [7:0]           w_rx_byte_nxt;
    logic                 w_edge_nxt;
    logic                 w_sclk_nxt;
    logic                 w_mosi_nxt;
    logic                 w_busy_nxt;
    logic [7:0]           w_frame_byte;
    logic [7:0]           w_load_byte;
    logic                 w_div_last;

    always_comb begin
        w_frame_byte = 8'hFF;
        case (spi_select)
            2'b01: w_frame_byte = tx_data;
            2'b10: begin
                case (byte_index)
                    4'd0:    w_frame_byte = {2'b01, cmd_index};
                    4'd1:    w_frame_byte = addr[31:24];
                    4'd2:    w_frame_byte = addr[23:16];
                    4'd3:    w_frame_byte = addr[15:8];
                    4'd4:    w_frame_byte = addr[7:0];
                    4'd5:    w_frame_byte = (cmd_index == 6'd0) ? CMD0_CRC : DEFAULT_CRC;
                    default: w_frame_byte = 8'hFF;
                endcase
            end
            default: w_frame_byte = 8'hFF;
        endcase
    end

    // A load in the boundary cycle itself is bypassed straight into the shifter
    assign w_load_byte = load_enable ? w_frame_byte :
                         r_pending   ? r_hold_byte  : 8'hFF;
    assign w_div_last  = (r_div_cnt == c_DIV_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div_cnt;
        w_bit_nxt       = r_bit_cnt;
        w_tx_nxt        = r_tx_shift;
        w_rx_nxt        = r_rx_shift;
        w_hold_nxt      = load_enable ? w_frame_byte : r_hold_byte;
        w_pend_nxt      = r_pending | load_enable;
        w_miso_prev_nxt = r_miso_prev;
        w_transf_nxt    = 1'b0;
        w_rx_byte_nxt   = rx_byte;
        w_edge_nxt      = 1'b0;

        case (r_state)
            S_HALT: begin
                if (enable) begin
                    w_tx_nxt    = w_load_byte;
                    w_pend_nxt  = 1'b0;
                    w_div_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                if (w_div_last) begin
                    w_div_nxt       = '0;
                    w_rx_nxt        = {r_rx_shift[6:0], miso};
                    w_edge_nxt      = r_miso_prev & ~miso;
                    w_miso_prev_nxt = miso;
                    w_state_nxt     = S_HIGH;
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (w_div_last) begin
                    w_div_nxt = '0;
                    if (r_bit_cnt != 3'd7) begin
                        w_tx_nxt    = {r_tx_shift[6:0], 1'b1};
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        w_state_nxt = S_LOW;
                    end else begin
                        w_transf_nxt  = 1'b1;
                        w_rx_byte_nxt = r_rx_shift;
                        w_bit_nxt     = 3'd0;
                        w_tx_nxt      = w_load_byte;
                        w_pend_nxt    = 1'b0;
                        w_state_nxt   = enable ? S_LOW : S_HALT;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + c_DIV_W'(1);
                end
            end
            default: w_state_nxt = S_HALT;
        endcase

        w_sclk_nxt = (w_state_nxt == S_HIGH);
        w_mosi_nxt = (w_state_nxt == S_HALT) ? 1'b1 : w_tx_nxt[7];
        w_busy_nxt = (w_state_nxt != S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HALT;
            r_div_cnt   <= '0;
            r_bit_cnt   <= 3'd0;
            r_tx_shift  <= 8'hFF;
            r_rx_shift  <= 8'hFF;
            r_hold_byte <= 8'hFF;
            r_pending   <= 1'b0;
            r_miso_prev <= 1'b1;
            sclk        <= 1'b0;
            mosi        <= 1'b1;
            byte_transf <= 1'b0;
            rx_byte     <= 8'hFF;
            edge_detect <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div_cnt   <= w_div_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_tx_shift  <= w_tx_nxt;
            r_rx_shift  <= w_rx_nxt;
            r_hold_byte <= w_hold_nxt;
            r_pending   <= w_pend_nxt;
            r_miso_prev <= w_miso_prev_nxt;
            sclk        <= w_sclk_nxt;
            mosi        <= w_mosi_nxt;
            byte_transf <= w_transf_nxt;
            rx_byte     <= w_rx_byte_nxt;
            edge_detect <= w_edge_nxt;
            busy        <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_spi_shifter
// Brief    : Self-checking bench: table vectors plus random byte streams
//            against a transaction-level model of the SPI byte engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_spi_shifter;

    localparam int unsigned CLK_DIV  = 4;
    localparam int          BYTE_CYC = 16 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load_enable = 1'b0;
    logic [1:0]  spi_select = 2'd0;
    logic [5:0]  cmd_index = 6'd0;
    logic [3:0]  byte_index = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [7:0]  tx_data = 8'd0;
    logic        miso = 1'b1;
    logic        sclk;
    logic        mosi;
    logic        byte_transf;
    logic [7:0]  rx_byte;
    logic        edge_detect;
    logic        busy;

    sd_spi_shifter #(
        .CLK_DIV     (CLK_DIV),
        .CMD0_CRC    (8'h95),
        .DEFAULT_CRC (8'hFF)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .load_enable (load_enable),
        .spi_select  (spi_select),
        .cmd_index   (cmd_index),
        .byte_index  (byte_index),
        .addr        (addr),
        .tx_data     (tx_data),
        .miso        (miso),
        .sclk        (sclk),
        .mosi        (mosi),
        .byte_transf (byte_transf),
        .rx_byte     (rx_byte),
        .edge_detect (edge_detect),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [5:0]  cmd;
        logic [3:0]  bidx;
        logic [31:0] addr;
        logic [7:0]  tx;
    } load_t;

    typedef struct {
        int         nload;
        load_t      l1;
        load_t      l2;
        int         off1;
        int         off2;
        logic [7:0] miso;
        logic [7:0] exp;
    } slot_t;

    typedef struct {
        bit         has_load;
        load_t      l;
        logic [7:0] miso;
        logic [7:0] exp;
        bit         last;
        int         halt_off;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] miso_q[$];
    slot_t      slots[$];
    vec_t       tbl[$];
    slot_t      s_tmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Frame contents straight from the command layout, by arithmetic
    function automatic logic [7:0] model_frame(input load_t l);
        int unsigned sh;
        if (l.sel == 2'd1) return l.tx;
        if (l.sel != 2'd2) return 8'hFF;
        if (l.bidx == 4'd0) return 8'(64 + l.cmd);
        if (l.bidx <= 4'd4) begin
            sh = 8 * (4 - int'(l.bidx));
            return 8'((l.addr >> sh) % 256);
        end
        if (l.bidx == 4'd5) return (l.cmd == 6'd0) ? 8'h95 : 8'hFF;
        return 8'hFF;
    endfunction

    function automatic load_t mkl(input logic [1:0] sel, input logic [5:0] cmd,
                                  input logic [3:0] bidx, input logic [31:0] a,
                                  input logic [7:0] tx);
        load_t l;
        l.sel = sel; l.cmd = cmd; l.bidx = bidx; l.addr = a; l.tx = tx;
        return l;
    endfunction

    function automatic vec_t mkv(input bit ld, input load_t l, input logic [7:0] mi,
                                 input logic [7:0] ex, input bit last, input int hoff);
        vec_t v;
        v.has_load = ld; v.l = l; v.miso = mi; v.exp = ex; v.last = last; v.halt_off = hoff;
        return v;
    endfunction

    function automatic load_t rand_load();
        return mkl(2'($urandom), 6'($urandom), 4'($urandom_range(0, 7)), $urandom, 8'($urandom));
    endfunction

    task automatic drive_load(input load_t l);
        spi_select = l.sel; cmd_index = l.cmd; byte_index = l.bidx; addr = l.addr; tx_data = l.tx;
    endtask

    task automatic scramble();
        spi_select = 2'($urandom); cmd_index = 6'($urandom); byte_index = 4'($urandom);
        addr = $urandom; tx_data = 8'($urandom);
    endtask

    // Plays the queued slots back-to-back from HALT; each slot k is loaded during byte k-1
    task automatic run_stream(input int halt_off);
        int n;
        n = slots.size();
        exp_q.push_back(slots[0].exp);
        miso_q.push_back(slots[0].miso);
        drive_load(slots[0].l1);
        load_enable = (slots[0].nload > 0);
        enable = 1'b1;
        @(negedge clk);
        load_enable = 1'b0;
        for (int k = 1; k < n; k++) begin
            exp_q.push_back(slots[k].exp);
            miso_q.push_back(slots[k].miso);
            for (int j = 0; j < BYTE_CYC; j++) begin
                load_enable = 1'b0;
                scramble();
                if (slots[k].nload > 0 && j == slots[k].off1) begin
                    drive_load(slots[k].l1); load_enable = 1'b1;
                end
                if (slots[k].nload > 1 && j == slots[k].off2) begin
                    drive_load(slots[k].l2); load_enable = 1'b1;
                end
                @(negedge clk);
            end
            load_enable = 1'b0;
            chk("transf_timing", {31'd0, byte_transf}, 32'd1);
        end
        for (int j = 0; j < BYTE_CYC; j++) begin
            if (j == halt_off) enable = 1'b0;
            scramble();
            @(negedge clk);
        end
        enable = 1'b0;
        chk("halt_transf", {31'd0, byte_transf}, 32'd1);
        chk("halt_busy",   {31'd0, busy}, 32'd0);
        chk("halt_sclk",   {31'd0, sclk}, 32'd0);
        chk("halt_mosi",   {31'd0, mosi}, 32'd1);
        repeat (3) @(negedge clk);
        chk("idle_busy",     {31'd0, busy}, 32'd0);
        chk("bytes_pending", exp_q.size(), 32'd0);
        slots.delete();
    endtask

    // Monitor: rebuilds mosi bytes from sclk rises and plays miso bytes back
    int         rcnt = 0;
    int         hi_len = 0;
    logic       prev_sclk = 1'b0;
    logic       mprev = 1'b1;
    logic       have_cur = 1'b0;
    logic [7:0] miso_cur = 8'hFF;
    logic [7:0] cap = 8'hFF;
    logic       bit_s;

    always @(negedge clk) begin
        if (rst) begin
            rcnt = 0; hi_len = 0; prev_sclk = 1'b0; mprev = 1'b1; have_cur = 1'b0;
            exp_q.delete(); miso_q.delete(); miso = 1'b1;
        end else begin
            if (!have_cur && miso_q.size() > 0) begin
                miso_cur = miso_q.pop_front(); have_cur = 1'b1;
            end
            if (sclk && !prev_sclk) begin
                bit_s = (have_cur && rcnt < 8) ? miso_cur[7 - rcnt] : 1'b1;
                chk("edge_detect", {31'd0, edge_detect}, {31'd0, mprev & ~bit_s});
                mprev = bit_s;
                cap = {cap[6:0], mosi};
                rcnt++;
                hi_len = 1;
            end else begin
                if (edge_detect) chk("edge_spurious", {31'd0, edge_detect}, 32'd0);
                if (sclk) hi_len++;
            end
            if (!sclk && prev_sclk) chk("sclk_high_len", hi_len, CLK_DIV);
            if (byte_transf) begin
                chk("bits_per_byte", rcnt, 8);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte: got byte_transf=1 expected none at %0t", $time);
                end else begin
                    chk("mosi_byte", {24'd0, cap}, {24'd0, exp_q.pop_front()});
                end
                chk("rx_byte", {24'd0, rx_byte}, {24'd0, have_cur ? miso_cur : 8'hFF});
                rcnt = 0;
                have_cur = 1'b0;
                if (miso_q.size() > 0) begin
                    miso_cur = miso_q.pop_front(); have_cur = 1'b1;
                end
            end
            miso = (have_cur && rcnt < 8) ? miso_cur[7 - rcnt] : 1'b1;
            prev_sclk = sclk;
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // fill, two command frames with misc selects, one data byte halted at bit 3
        tbl.push_back(mkv(0, mkl(0, 0, 0, 0, 0), 8'hFF, 8'hFF, 0, 0));
        tbl.push_back(mkv(0, mkl(0, 0, 0, 0, 0), 8'hFF, 8'hFF, 0, 0));
        tbl.push_back(mkv(0, mkl(0, 0, 0, 0, 0), 8'hFF, 8'hFF, 1, 0));
        tbl.push_back(mkv(1, mkl(2, 0, 0, 0, 0), 8'hFF, 8'h40, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 0, 1, 0, 0), 8'hFF, 8'h00, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 0, 2, 0, 0), 8'h00, 8'h00, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 0, 3, 0, 0), 8'hFF, 8'h00, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 0, 4, 0, 0), 8'h5A, 8'h00, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 0, 5, 0, 0), 8'h00, 8'h95, 1, 5));
        tbl.push_back(mkv(1, mkl(2, 17, 0, 32'h12345678, 0), 8'h0F, 8'h51, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 17, 1, 32'h12345678, 0), 8'hF0, 8'h12, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 17, 2, 32'h12345678, 0), 8'h81, 8'h34, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 17, 3, 32'h12345678, 0), 8'h7E, 8'h56, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 17, 4, 32'h12345678, 0), 8'hC3, 8'h78, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 17, 5, 32'h12345678, 0), 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mkv(1, mkl(2, 17, 9, 32'h12345678, 0), 8'hAA, 8'hFF, 0, 0));
        tbl.push_back(mkv(1, mkl(3, 17, 0, 32'h12345678, 8'h11), 8'h55, 8'hFF, 0, 0));
        tbl.push_back(mkv(1, mkl(0, 17, 0, 32'h12345678, 8'h22), 8'hFF, 8'hFF, 1, 40));
        tbl.push_back(mkv(1, mkl(1, 0, 0, 0, 8'hA5), 8'h3C, 8'hA5, 1, 26));

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sclk",   {31'd0, sclk}, 32'd0);
        chk("rst_mosi",   {31'd0, mosi}, 32'd1);
        chk("rst_transf", {31'd0, byte_transf}, 32'd0);
        chk("rst_edge",   {31'd0, edge_detect}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_rx",     {24'd0, rx_byte}, 32'hFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            s_tmp.nload = tbl[i].has_load ? 1 : 0;
            s_tmp.l1    = tbl[i].l;
            s_tmp.l2    = tbl[i].l;
            s_tmp.off1  = $urandom_range(0, BYTE_CYC - 1);
            s_tmp.off2  = BYTE_CYC;
            s_tmp.miso  = tbl[i].miso;
            s_tmp.exp   = tbl[i].exp;
            slots.push_back(s_tmp);
            if (tbl[i].last) run_stream(tbl[i].halt_off);
        end

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 12; k++) begin
                s_tmp.nload = (k == 0) ? $urandom_range(0, 1) : $urandom_range(0, 2);
                s_tmp.l1    = rand_load();
                s_tmp.l2    = rand_load();
                s_tmp.off1  = $urandom_range(0, BYTE_CYC - 2);
                s_tmp.off2  = $urandom_range(s_tmp.off1 + 1, BYTE_CYC - 1);
                s_tmp.miso  = 8'($urandom);
                s_tmp.exp   = (s_tmp.nload == 0) ? 8'hFF :
                              (s_tmp.nload == 1) ? model_frame(s_tmp.l1) : model_frame(s_tmp.l2);
                slots.push_back(s_tmp);
            end
            run_stream($urandom_range(0, BYTE_CYC - 1));
        end

        // reset in the middle of a byte aborts it without a byte_transf
        enable = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("midrst_sclk",   {31'd0, sclk}, 32'd0);
        chk("midrst_mosi",   {31'd0, mosi}, 32'd1);
        chk("midrst_transf", {31'd0, byte_transf}, 32'd0);
        chk("midrst_edge",   {31'd0, edge_detect}, 32'd0);
        chk("midrst_busy",   {31'd0, busy}, 32'd0);
        chk("midrst_rx",     {24'd0, rx_byte}, 32'hFF);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_sclk", {31'd0, sclk}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
